// File: rtl/dmem_lat_model.sv
// Single-port data-memory model for the core's dmem load/store interface.
// Provides configurable depth, load latency, store byte lanes, error pulses and access counters.
`timescale 1ns/1ps
module dmem_lat_model #(
  parameter int unsigned          ADDR_LEN    = 32,
  parameter int unsigned          DEPTH_WORDS = 1024,
  parameter int unsigned          LOAD_LAT    = 1,
  parameter logic [ADDR_LEN-1:0]  BASE_ADDR   = '0
) (
  input  logic                clk,
  input  logic                c_arst,
  input  logic                c_dmem_load,
  input  logic [ADDR_LEN-1:0] dmem_load_addr,
  output logic [31:0]         dmem_load_data,
  output logic                c_dmem_load_valid,
  input  logic                c_dmem_store,
  input  logic [ADDR_LEN-1:0] dmem_store_addr,
  input  logic [1:0]          dmem_store_width,
  input  logic [31:0]         dmem_store_data,
  output logic                c_dmem_err,
  output logic [15:0]         load_cnt,
  output logic [15:0]         store_cnt
);

  localparam int unsigned        IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_LEN:0]  SPAN  = (ADDR_LEN+1)'(DEPTH_WORDS * 4);

  logic [31:0] mem [DEPTH_WORDS];

  // Offsets relative to the window base; the range test is unsigned, so addresses below the base wrap high.
  logic [ADDR_LEN-1:0] ld_off, st_off;
  logic [IDX_W-1:0]    ld_idx, st_idx;
  logic                ld_in_range, st_in_range;

  assign ld_off      = dmem_load_addr - BASE_ADDR;
  assign st_off      = dmem_store_addr - BASE_ADDR;
  assign ld_in_range = {1'b0, ld_off} < SPAN;
  assign st_in_range = {1'b0, st_off} < SPAN;
  assign ld_idx      = ld_off[IDX_W+1:2];
  assign st_idx      = st_off[IDX_W+1:2];

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        st_fmt_ok;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    st_be     = 4'b0000;
    st_wdata  = dmem_store_data;
    st_fmt_ok = 1'b0;
    case (dmem_store_width)
      2'd0: begin
        st_fmt_ok = 1'b1;
        st_be     = 4'b0001 << st_off[1:0];
        st_wdata  = {4{dmem_store_data[7:0]}};
      end
      2'd1: begin
        st_fmt_ok = ~st_off[0];
        st_be     = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata  = {2{dmem_store_data[15:0]}};
      end
      2'd2: begin
        st_fmt_ok = (st_off[1:0] == 2'b00);
        st_be     = 4'b1111;
      end
      default: ;
    endcase
  end

  logic        st_accept, ld_accept, acc_err;
  logic [31:0] ld_word;

  assign st_accept = c_dmem_store & st_fmt_ok & st_in_range;
  assign ld_accept = c_dmem_load & ld_in_range;
  assign acc_err   = (c_dmem_load & ~ld_in_range) | (c_dmem_store & ~st_accept);
  assign ld_word   = ld_in_range ? mem[ld_idx] : 32'h0;

  // NOTE: the memory array has no reset; its contents survive c_arst and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (st_accept) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[st_idx][8*b +: 8] <= st_wdata[8*b +: 8];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge c_arst) begin
    if (c_arst) begin
      c_dmem_err <= 1'b0;
      load_cnt   <= '0;
      store_cnt  <= '0;
    end else begin
      c_dmem_err <= acc_err;
      if (ld_accept) load_cnt  <= load_cnt + 16'd1;
      if (st_accept) store_cnt <= store_cnt + 16'd1;
    end
  end

  generate
    if (LOAD_LAT == 0) begin : g_comb
      logic [31:0] hold_q;

      always_ff @(posedge clk or posedge c_arst) begin
        if (c_arst)           hold_q <= '0;
        else if (c_dmem_load) hold_q <= ld_word;
      end

      // The read sees the array before this cycle's store lands, giving read-before-write.
      assign c_dmem_load_valid = c_dmem_load & ~c_arst;
      assign dmem_load_data    = c_arst ? 32'h0 : (c_dmem_load ? ld_word : hold_q);
    end else begin : g_pipe
      logic [LOAD_LAT-1:0] vld_q;
      logic [31:0]         data_q [LOAD_LAT];

      // Each data stage only moves with a valid token, so the output holds the last result.
      always_ff @(posedge clk or posedge c_arst) begin
        if (c_arst) begin
          vld_q <= '0;
          for (int i = 0; i < int'(LOAD_LAT); i++) data_q[i] <= '0;
        end else begin
          vld_q[0] <= c_dmem_load;
          if (c_dmem_load) data_q[0] <= ld_word;
          for (int i = 1; i < int'(LOAD_LAT); i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) data_q[i] <= data_q[i-1];
          end
        end
      end

      assign c_dmem_load_valid = vld_q[LOAD_LAT-1];
      assign dmem_load_data    = data_q[LOAD_LAT-1];
    end
  endgenerate

endmodule

// File: tb/tb_dmem_lat_model.sv
// Bench for dmem_lat_model: four instances (LOAD_LAT 0,2,3,4) share stimulus; a byte-level
// reference memory feeds per-instance expectation queues that a negedge monitor drains.
`timescale 1ns/1ps
module tb_dmem_lat_model;

  localparam int          NDUT  = 4;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0;
  localparam logic [31:0] SPAN  = DEPTH * 4;

  logic        clk, c_arst;
  logic        c_dmem_load, c_dmem_store;
  logic [31:0] ld_addr, st_addr, st_data;
  logic [1:0]  st_width;

  logic [31:0] ld_data  [NDUT];
  logic        ld_valid [NDUT];
  logic        err      [NDUT];
  logic [15:0] lcnt     [NDUT];
  logic [15:0] scnt     [NDUT];

  function automatic int lat_of(input int g);
    return (g == 0) ? 0 : g + 1;
  endfunction

  generate
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
      dmem_lat_model #(
        .ADDR_LEN(32), .DEPTH_WORDS(DEPTH), .LOAD_LAT((g == 0) ? 0 : g + 1), .BASE_ADDR(BASE)
      ) u_dut (
        .clk(clk), .c_arst(c_arst),
        .c_dmem_load(c_dmem_load), .dmem_load_addr(ld_addr),
        .dmem_load_data(ld_data[g]), .c_dmem_load_valid(ld_valid[g]),
        .c_dmem_store(c_dmem_store), .dmem_store_addr(st_addr),
        .dmem_store_width(st_width), .dmem_store_data(st_data),
        .c_dmem_err(err[g]), .load_cnt(lcnt[g]), .store_cnt(scnt[g])
      );
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] data; } ld_exp_t;
  typedef struct { int cyc; bit err; logic [15:0] lc; logic [15:0] sc; } st_exp_t;

  ld_exp_t     ldq [NDUT][$];
  st_exp_t     stq [$];
  logic [31:0] last_data [NDUT];
  logic [7:0]  mm [DEPTH*4];
  logic [15:0] exp_lc, exp_sc;
  int          n_vec = 0, n_fail = 0;
  bit          started = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory and the access rules in plain arithmetic.
  function automatic bit in_range(input logic [31:0] a);
    return (a - BASE) < SPAN;
  endfunction

  function automatic bit store_ok(input logic [31:0] a, input logic [1:0] w);
    if (w == 2'd3) return 1'b0;
    if (w == 2'd1 && a[0]) return 1'b0;
    if (w == 2'd2 && a[1:0] != 2'b00) return 1'b0;
    return in_range(a);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int b;
    b = int'((a - BASE) & ~32'h3);
    return {mm[b+3], mm[b+2], mm[b+1], mm[b]};
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    int b;
    b = int'(a - BASE);
    for (int k = 0; k < (1 << w); k++) mm[b+k] = d[8*k +: 8];
  endtask

  // One bus cycle: drive requests, then record what the DUTs must show later.
  task automatic cycle_op(input bit ld, input logic [31:0] la, input bit st,
                          input logic [31:0] sa, input logic [1:0] sw, input logic [31:0] sd);
    logic [31:0] rd;
    bit          e;
    @(posedge clk); #1;
    c_dmem_load = ld; ld_addr = la;
    c_dmem_store = st; st_addr = sa; st_width = sw; st_data = sd;
    e = 1'b0;
    if (ld) begin
      rd = in_range(la) ? model_read(la) : 32'h0;
      for (int g = 0; g < NDUT; g++) ldq[g].push_back('{cyc + lat_of(g), rd});
      if (in_range(la)) exp_lc++;
      else e = 1'b1;
    end
    if (st) begin
      if (store_ok(sa, sw)) begin
        model_write(sa, sw, sd);
        exp_sc++;
      end else e = 1'b1;
    end
    stq.push_back('{cyc + 1, e, exp_lc, exp_sc});
  endtask

  task automatic idle(input int n);
    repeat (n) cycle_op(1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    c_arst = 1'b1; started = 1'b1;
    c_dmem_load = 1'b0; c_dmem_store = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      ldq[g].delete();
      last_data[g] = 32'h0;
    end
    stq.delete();
    exp_lc = '0; exp_sc = '0;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("rst_valid[lat%0d]", lat_of(g)), 32'(ld_valid[g]), 32'h0);
      check($sformatf("rst_data[lat%0d]", lat_of(g)), ld_data[g], 32'h0);
      check($sformatf("rst_err[lat%0d]", lat_of(g)), 32'(err[g]), 32'h0);
      check($sformatf("rst_load_cnt[lat%0d]", lat_of(g)), 32'(lcnt[g]), 32'h0);
      check($sformatf("rst_store_cnt[lat%0d]", lat_of(g)), 32'(scnt[g]), 32'h0);
    end
    repeat (2) @(posedge clk);
    #1 c_arst = 1'b0;
  endtask

  // Monitor: compares DUT outputs against the queued expectations, away from the clock edge.
  always @(negedge clk) begin
    if (started && !c_arst) begin
      for (int g = 0; g < NDUT; g++) begin
        bit      exp_v;
        ld_exp_t e;
        exp_v = (ldq[g].size() > 0) && (ldq[g][0].cyc == cyc);
        check($sformatf("valid[lat%0d]", lat_of(g)), 32'(ld_valid[g]), 32'(exp_v));
        if (ld_valid[g] && ldq[g].size() > 0) begin
          e = ldq[g].pop_front();
          check($sformatf("latency_cycle[lat%0d]", lat_of(g)), cyc, e.cyc);
          check($sformatf("load_data[lat%0d]", lat_of(g)), ld_data[g], e.data);
          last_data[g] = e.data;
        end else if (!ld_valid[g]) begin
          check($sformatf("hold_data[lat%0d]", lat_of(g)), ld_data[g], last_data[g]);
        end
      end
      if (stq.size() > 0 && stq[0].cyc == cyc) begin
        st_exp_t s;
        s = stq.pop_front();
        for (int g = 0; g < NDUT; g++) begin
          check($sformatf("err[lat%0d]", lat_of(g)), 32'(err[g]), 32'(s.err));
          check($sformatf("load_cnt[lat%0d]", lat_of(g)), 32'(lcnt[g]), 32'(s.lc));
          check($sformatf("store_cnt[lat%0d]", lat_of(g)), 32'(scnt[g]), 32'(s.sc));
        end
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 7) return 32'($urandom_range(0, SPAN - 1));
    if (r < 9) return SPAN + 32'($urandom_range(0, 15));
    return $urandom;
  endfunction

  initial begin
    c_arst = 1'b0; c_dmem_load = 1'b0; c_dmem_store = 1'b0;
    ld_addr = '0; st_addr = '0; st_width = '0; st_data = '0;
    exp_lc = '0; exp_sc = '0;
    do_reset();

    for (int i = 0; i < DEPTH; i++) cycle_op(1'b0, 32'h0, 1'b1, 32'(i * 4), 2'd2, $urandom);
    do_reset();

    // Word store then load of the same address.
    cycle_op(1'b0, 32'h0, 1'b1, 32'h10, 2'd2, 32'hDEADBEEF);
    cycle_op(1'b1, 32'h10, 1'b0, 32'h0, 2'd0, 32'h0);
    idle(6);

    // Byte and half lanes merge into one word.
    cycle_op(1'b0, 32'h0, 1'b1, 32'h20, 2'd2, 32'h11223344);
    cycle_op(1'b0, 32'h0, 1'b1, 32'h21, 2'd0, 32'hFFFF_FFAA);
    cycle_op(1'b0, 32'h0, 1'b1, 32'h22, 2'd1, 32'h1234_BEEF);
    cycle_op(1'b1, 32'h20, 1'b0, 32'h0, 2'd0, 32'h0);
    idle(6);

    // Rejected stores and an out-of-range load.
    cycle_op(1'b0, 32'h0, 1'b1, 32'h31, 2'd1, 32'hAAAA_AAAA);
    cycle_op(1'b0, 32'h0, 1'b1, 32'h32, 2'd2, 32'hBBBB_BBBB);
    cycle_op(1'b0, 32'h0, 1'b1, 32'h30, 2'd3, 32'hCCCC_CCCC);
    cycle_op(1'b0, 32'h0, 1'b1, SPAN, 2'd2, 32'hDDDD_DDDD);
    cycle_op(1'b1, 32'h30, 1'b0, 32'h0, 2'd0, 32'h0);
    cycle_op(1'b1, SPAN, 1'b0, 32'h0, 2'd0, 32'h0);
    cycle_op(1'b1, 32'h33, 1'b1, SPAN + 32'h4, 2'd0, 32'h0);
    idle(6);

    // Same-cycle load and store to one word: read-before-write.
    cycle_op(1'b0, 32'h0, 1'b1, 32'h40, 2'd2, 32'h7);
    cycle_op(1'b1, 32'h40, 1'b1, 32'h40, 2'd2, 32'h5);
    cycle_op(1'b1, 32'h40, 1'b0, 32'h0, 2'd0, 32'h0);
    idle(6);

    // Back-to-back loads, then reset with loads in flight.
    for (int i = 0; i < 4; i++) cycle_op(1'b0, 32'h0, 1'b1, 32'(i * 4), 2'd2, 32'(i + 1));
    for (int i = 0; i < 4; i++) cycle_op(1'b1, 32'(i * 4), 1'b0, 32'h0, 2'd0, 32'h0);
    idle(6);
    cycle_op(1'b1, 32'h0, 1'b0, 32'h0, 2'd0, 32'h0);
    cycle_op(1'b1, 32'h4, 1'b0, 32'h0, 2'd0, 32'h0);
    do_reset();
    idle(6);
    for (int i = 0; i < 4; i++) cycle_op(1'b1, 32'(i * 4), 1'b0, 32'h0, 2'd0, 32'h0);
    idle(6);

    // Randomised mix, with frequent same-word collisions.
    repeat (1500) begin
      logic [31:0] la, sa;
      la = rand_addr();
      sa = rand_addr();
      if ($urandom_range(0, 3) == 0) sa = {la[31:2], 2'($urandom_range(0, 3))};
      cycle_op(1'($urandom_range(0, 1)), la, 1'($urandom_range(0, 1)), sa,
               2'($urandom_range(0, 3)), $urandom);
    end
    idle(6);

    // Store counter wrap.
    do_reset();
    for (int i = 0; i < 65537; i++) cycle_op(1'b0, 32'h0, 1'b1, 32'h8, 2'd2, 32'(i));
    cycle_op(1'b1, 32'h8, 1'b0, 32'h0, 2'd0, 32'h0);
    idle(6);
    do_reset();
    idle(8);

    for (int g = 0; g < NDUT; g++)
      check($sformatf("pending_loads[lat%0d]", lat_of(g)), 32'(ldq[g].size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded its time limit at cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
